wf_rr_arbiter: RTL and testbench

Round-robin wavefront arbiter for the 40 wavefront slots of a compute unit. Each cycle it selects one ready wavefront from a 40-bit request vector, starting the search at a rotating priority base. It presents the winner through a registered valid/ready output. After each accepted grant the base advances to the winner's slot + 1, modulo 40. It sits between the per-slot ready logic and the issue stage that consumes a wavefront ID.

---
 rtl/wf_rr_arbiter_pkg.sv | 36 +++
 rtl/wf_rr_arbiter_if.sv | 41 ++++
 rtl/wf_rr_pick.sv | 30 +++
 rtl/wf_rr_arbiter.sv | 89 ++++++++
 tb/tb_wf_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wf_rr_arbiter_pkg.sv
// Shared definitions for the round-robin wavefront arbiter.
// Holds the slot count, ID width, the mod-40 wrap subtrahend, the grant
// register payload and a mod-NUM_WF add helper.
package wf_rr_arbiter_pkg;

   localparam int unsigned NUM_WF = 40;
   localparam int unsigned WFID_W = 6;
   localparam int unsigned SUM_W  = 7;

   // Adding this value in SUM_W bits subtracts NUM_WF (two's complement).
   localparam logic [SUM_W-1:0] WRAP_SUB = SUM_W'((1 << SUM_W) - NUM_WF);

   typedef logic [WFID_W-1:0] wfid_t;
   typedef logic [NUM_WF-1:0] wfvec_t;

   typedef struct packed {
      logic   valid;
      wfid_t  wfid;
      wfvec_t onehot;
   } grant_t;

   // (a + b) mod NUM_WF for a, b already in 0..NUM_WF-1.
   function automatic wfid_t wf_wrap_add(input wfid_t a, input wfid_t b);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + SUM_W'(b);
      if (sum >= SUM_W'(NUM_WF)) begin
         sum = sum + WRAP_SUB;
      end
      return WFID_W'(sum);
   endfunction

   function automatic wfid_t wf_inc(input wfid_t a);
      return wf_wrap_add(a, WFID_W'(1));
   endfunction

endpackage

// File: rtl/wf_rr_arbiter_if.sv
// Handshake bundle between per-slot ready logic, the arbiter and the issue stage.
// slave : arbiter side (takes req/flush/out_ready, drives the grant and prio_base).
// master: environment side.
// Optional macro WF_ARB_PERF_CNT_EN adds perf_grants / perf_stalls.
interface wf_rr_arbiter_if import wf_rr_arbiter_pkg::*; ();

   wfvec_t      req;
   logic        flush;
   logic        out_ready;
   logic        grant_valid;
   wfid_t       grant_wfid;
   wfvec_t      grant_onehot;
   wfid_t       prio_base;
`ifdef WF_ARB_PERF_CNT_EN
   logic [31:0] perf_grants;
   logic [31:0] perf_stalls;

   modport slave (
      input  req, flush, out_ready,
      output grant_valid, grant_wfid, grant_onehot, prio_base,
      output perf_grants, perf_stalls
   );

   modport master (
      output req, flush, out_ready,
      input  grant_valid, grant_wfid, grant_onehot, prio_base,
      input  perf_grants, perf_stalls
   );
`else
   modport slave (
      input  req, flush, out_ready,
      output grant_valid, grant_wfid, grant_onehot, prio_base
   );

   modport master (
      output req, flush, out_ready,
      input  grant_valid, grant_wfid, grant_onehot, prio_base
   );
`endif

endinterface

// File: rtl/wf_rr_pick.sv
// Rotating first-one finder: returns the first set bit of vec searching
// start, start+1, ..., NUM_WF-1, 0, ..., start-1. Purely combinational.
// Ports: vec (NUM_WF candidates), start (search origin),
//        found (any bit set), id (winning slot, 0 when none).
module wf_rr_pick
   import wf_rr_arbiter_pkg::*;
(
   input  wfvec_t vec,
   input  wfid_t  start,
   output logic   found,
   output wfid_t  id
);

   wfid_t idx;

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      found = 1'b0;
      id    = '0;
      idx   = '0;
      for (int k = NUM_WF - 1; k >= 0; k--) begin
         idx = wf_wrap_add(start, WFID_W'(k));
         if (vec[idx]) begin
            found = 1'b1;
            id    = idx;
         end
      end
   end

endmodule

// File: rtl/wf_rr_arbiter.sv
// Round-robin wavefront arbiter for the NUM_WF slots of a compute unit.
// Picks one eligible slot per cycle from a rotating base and holds it in a
// registered valid/ready output until the issue stage accepts it.
// Ports: clk, rst (synchronous, active-high), bus (wf_rr_arbiter_if.slave:
//        req, flush, out_ready in; grant_valid, grant_wfid, grant_onehot,
//        prio_base out).
// Optional macro WF_ARB_PERF_CNT_EN adds perf_grants / perf_stalls counters.
module wf_rr_arbiter
   import wf_rr_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   wf_rr_arbiter_if.slave   bus
);

   grant_t grant_q;
   wfid_t  base_q;

   logic   accept_c;
   logic   load_c;
   wfid_t  next_base_c;
   wfvec_t mreq_c;
   logic   found_c;
   wfid_t  pick_id_c;

   assign accept_c    = grant_q.valid & bus.out_ready;
   assign load_c      = (~grant_q.valid | accept_c) & ~bus.flush;
   // Search origin assumes the held grant retires, so the next pick skips past it.
   assign next_base_c = grant_q.valid ? wf_inc(grant_q.wfid) : base_q;
   // A held grant is never a candidate for its own replacement.
   assign mreq_c      = bus.req & ~grant_q.onehot;

   wf_rr_pick u_pick (
      .vec   (mreq_c),
      .start (next_base_c),
      .found (found_c),
      .id    (pick_id_c)
   );

   // Grant register and priority base.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= '0;
         base_q  <= '0;
      end else begin
         if (accept_c) begin
            base_q <= wf_inc(grant_q.wfid);
         end
         if (bus.flush) begin
            // ID is left as-is; only validity and the one-hot are cleared.
            grant_q.valid  <= 1'b0;
            grant_q.onehot <= '0;
         end else if (load_c) begin
            grant_q.valid  <= found_c;
            grant_q.wfid   <= pick_id_c;
            grant_q.onehot <= found_c ? (wfvec_t'(1) << pick_id_c) : '0;
         end
      end
   end

   assign bus.grant_valid  = grant_q.valid;
   assign bus.grant_wfid   = grant_q.wfid;
   assign bus.grant_onehot = grant_q.onehot;
   assign bus.prio_base    = base_q;

`ifdef WF_ARB_PERF_CNT_EN
   logic [31:0] perf_grants_q;
   logic [31:0] perf_stalls_q;

   // Accept and stall counters; both wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grants_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         if (accept_c) begin
            perf_grants_q <= perf_grants_q + 32'd1;
         end
         if (grant_q.valid && !bus.out_ready) begin
            perf_stalls_q <= perf_stalls_q + 32'd1;
         end
      end
   end

   assign bus.perf_grants = perf_grants_q;
   assign bus.perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_wf_rr_arbiter.sv
// Self-checking bench for wf_rr_arbiter: directed scenarios plus randomized
// traffic compared against a slot-level behavioural model.
module tb_wf_rr_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   wf_rr_arbiter_if bus ();

   wf_rr_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   bit          m_valid;
   int          m_wfid;
   int          m_base;
   logic [31:0] m_grants;
   logic [31:0] m_stalls;

   function automatic logic [39:0] bitv(input int i);
      logic [39:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Drive one cycle of inputs, advance the model, sample #1 after the edge.
   task automatic cycle(input logic r, input logic [39:0] rq, input logic fl, input logic ordy);
      bit          n_valid;
      int          n_wfid;
      int          n_base;
      int          start;
      int          idx;
      bit          acc;
      logic [31:0] n_grants;
      logic [31:0] n_stalls;
      rst           = r;
      bus.req       = rq;
      bus.flush     = fl;
      bus.out_ready = ordy;
      n_valid  = m_valid;
      n_wfid   = m_wfid;
      n_base   = m_base;
      n_grants = m_grants;
      n_stalls = m_stalls;
      if (r) begin
         n_valid = 0; n_wfid = 0; n_base = 0; n_grants = 0; n_stalls = 0;
      end else begin
         acc = m_valid && ordy;
         if (acc) n_grants = m_grants + 32'd1;
         if (m_valid && !ordy) n_stalls = m_stalls + 32'd1;
         if (acc) n_base = (m_wfid + 1) % 40;
         if (fl) begin
            n_valid = 0;
         end else if (!m_valid || acc) begin
            start   = m_valid ? (m_wfid + 1) % 40 : m_base;
            n_valid = 0;
            for (int k = 0; k < 40; k++) begin
               idx = (start + k) % 40;
               if (!n_valid && rq[idx] && !(m_valid && idx == m_wfid)) begin
                  n_valid = 1;
                  n_wfid  = idx;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      m_valid  = n_valid;
      m_wfid   = n_wfid;
      m_base   = n_base;
      m_grants = n_grants;
      m_stalls = n_stalls;
   endtask

   task automatic do_reset();
      cycle(1'b1, '0, 1'b0, 1'b0);
      cycle(1'b1, '0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_wfid !== 6'd0 || bus.grant_onehot !== 40'd0 || bus.prio_base !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%0d id=%0d oh=%h base=%0d expected all zero",
                  bus.grant_valid, bus.grant_wfid, bus.grant_onehot, bus.prio_base);
      end
      cycle(1'b0, '0, 1'b0, 1'b1);
      n_checks++;
      if (bus.grant_valid !== 1'b0 || bus.prio_base !== 6'd0) begin
         n_fail++;
         $display("FAIL idle_no_req: got v=%0d base=%0d expected v=0 base=0", bus.grant_valid, bus.prio_base);
      end
      cycle(1'b0, bitv(5), 1'b0, 1'b1);
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_wfid !== 6'd5 || bus.grant_onehot !== bitv(5)) begin
         n_fail++;
         $display("FAIL first_grant: got v=%0d id=%0d expected v=1 id=5", bus.grant_valid, bus.grant_wfid);
      end
   endtask

   task automatic test_rotation();
      int g [3] = '{3, 10, 39};
      int b [3] = '{4, 11, 0};
      logic [39:0] rq;
      rq = bitv(3) | bitv(10) | bitv(39);
      do_reset();
      cycle(1'b0, rq, 1'b0, 1'b1);
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_wfid !== 6'd3 || bus.prio_base !== 6'd0) begin
         n_fail++;
         $display("FAIL rot_first: got v=%0d id=%0d base=%0d expected v=1 id=3 base=0",
                  bus.grant_valid, bus.grant_wfid, bus.prio_base);
      end
      for (int k = 2; k <= 7; k++) begin
         cycle(1'b0, rq, 1'b0, 1'b1);
         n_checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant_wfid !== 6'(g[(k-1)%3]) || bus.prio_base !== 6'(b[(k-2)%3])) begin
            n_fail++;
            $display("FAIL rot_step%0d: got v=%0d id=%0d base=%0d expected v=1 id=%0d base=%0d",
                     k, bus.grant_valid, bus.grant_wfid, bus.prio_base, g[(k-1)%3], b[(k-2)%3]);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      cycle(1'b0, bitv(39), 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, {$urandom(), $urandom()}, 1'b0, 1'b0);
         n_checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant_wfid !== 6'd39 || bus.grant_onehot !== bitv(39) || bus.prio_base !== 6'd0) begin
            n_fail++;
            $display("FAIL hold_%0d: got v=%0d id=%0d base=%0d expected v=1 id=39 base=0",
                     k, bus.grant_valid, bus.grant_wfid, bus.prio_base);
         end
      end
      cycle(1'b0, bitv(2) | bitv(17) | bitv(39), 1'b0, 1'b1);
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_wfid !== 6'd2 || bus.prio_base !== 6'd0) begin
         n_fail++;
         $display("FAIL hold_release: got v=%0d id=%0d base=%0d expected v=1 id=2 base=0",
                  bus.grant_valid, bus.grant_wfid, bus.prio_base);
      end
   endtask

   task automatic test_lone_requester();
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         cycle(1'b0, bitv(7), 1'b0, 1'b1);
         n_checks++;
         if (bus.grant_valid !== 1'((k % 2) == 1) || (bus.grant_valid === 1'b1 && bus.grant_wfid !== 6'd7)) begin
            n_fail++;
            $display("FAIL lone_%0d: got v=%0d id=%0d expected v=%0d id=7",
                     k, bus.grant_valid, bus.grant_wfid, (k % 2));
         end
      end
   endtask

   task automatic test_flush();
      logic [39:0] rq;
      rq = bitv(20) | bitv(25);
      do_reset();
      cycle(1'b0, bitv(20), 1'b0, 1'b0);
      cycle(1'b0, rq, 1'b1, 1'b1);
      n_checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 40'd0 || bus.grant_wfid !== 6'd20 || bus.prio_base !== 6'd21) begin
         n_fail++;
         $display("FAIL flush_accept: got v=%0d id=%0d oh=%h base=%0d expected v=0 id=20 oh=0 base=21",
                  bus.grant_valid, bus.grant_wfid, bus.grant_onehot, bus.prio_base);
      end
      cycle(1'b0, rq, 1'b0, 1'b1);
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_wfid !== 6'd25) begin
         n_fail++;
         $display("FAIL flush_reload: got v=%0d id=%0d expected v=1 id=25", bus.grant_valid, bus.grant_wfid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cycle(1'b0, bitv(12), 1'b0, 1'b0);
      cycle(1'b0, bitv(12), 1'b0, 1'b0);
      cycle(1'b0, bitv(12), 1'b0, 1'b0);
`ifdef WF_ARB_PERF_CNT_EN
      n_checks++;
      if (bus.perf_stalls !== 32'd2 || bus.perf_grants !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_pre_reset: got grants=%0d stalls=%0d expected grants=0 stalls=2",
                  bus.perf_grants, bus.perf_stalls);
      end
`endif
      cycle(1'b1, bitv(12), 1'b0, 1'b0);
      n_checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_wfid !== 6'd0 || bus.grant_onehot !== 40'd0 || bus.prio_base !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got v=%0d id=%0d oh=%h base=%0d expected all zero",
                  bus.grant_valid, bus.grant_wfid, bus.grant_onehot, bus.prio_base);
      end
`ifdef WF_ARB_PERF_CNT_EN
      n_checks++;
      if (bus.perf_stalls !== 32'd0 || bus.perf_grants !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_reset: got grants=%0d stalls=%0d expected 0 0", bus.perf_grants, bus.perf_stalls);
      end
`endif
   endtask

   task automatic test_fairness();
      bit seen [40];
      int distinct;
      int prev;
      int repeats;
      distinct = 0;
      repeats  = 0;
      prev     = -1;
      foreach (seen[i]) seen[i] = 0;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         cycle(1'b0, '1, 1'b0, 1'b1);
         if (bus.grant_valid === 1'b1) begin
            if (!seen[int'(bus.grant_wfid) % 40]) distinct++;
            seen[int'(bus.grant_wfid) % 40] = 1;
            if (int'(bus.grant_wfid) == prev) repeats++;
            prev = int'(bus.grant_wfid);
         end
      end
      n_checks++;
      if (distinct != 40 || repeats != 0) begin
         n_fail++;
         $display("FAIL fairness: got distinct=%0d repeats=%0d expected distinct=40 repeats=0", distinct, repeats);
      end
   endtask

   task automatic test_random();
      logic [39:0] rq;
      logic [39:0] exp_oh;
      int          bad;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         rq = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
         if ($urandom_range(0, 7) == 0) rq = '0;
         cycle(1'b0, rq, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
         exp_oh = m_valid ? bitv(m_wfid) : 40'd0;
         bad = 0;
         n_checks++;
         if (bus.grant_valid !== 1'(m_valid) || bus.grant_onehot !== exp_oh || bus.prio_base !== 6'(m_base)) bad = 1;
         if (m_valid && bus.grant_wfid !== 6'(m_wfid)) bad = 1;
`ifdef WF_ARB_PERF_CNT_EN
         if (bus.perf_grants !== m_grants || bus.perf_stalls !== m_stalls) bad = 1;
`endif
         if (bad != 0) begin
            n_fail++;
            $display("FAIL random_%0d: got v=%0d id=%0d base=%0d expected v=%0d id=%0d base=%0d",
                     k, bus.grant_valid, bus.grant_wfid, bus.prio_base, m_valid, m_wfid, m_base);
         end
      end
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      m_valid       = 0;
      m_wfid        = 0;
      m_base        = 0;
      m_grants      = '0;
      m_stalls      = '0;
      rst           = 1'b1;
      bus.req       = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_rotation();
      test_hold();
      test_lone_requester();
      test_flush();
      test_reset_mid();
      test_fairness();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
